// File: rtl/vc_flow_arbiter.sv
// vc_flow_arbiter: two per-channel FIFOs merged round-robin into one registered stream,
// with hysteretic pause feedback to the upstream hold/translate selectors.
module vc_flow_arbiter #(
  parameter int BW      = 10,
  parameter int DEPTH   = 4,
  parameter int AW      = 2,
  parameter int HIGH_TH = 3,
  parameter int LOW_TH  = 1
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          ENB,
  input  logic          valid0_in,
  input  logic [BW-1:0] data0_in,
  input  logic          valid1_in,
  input  logic [BW-1:0] data1_in,
  input  logic          out_ready,
  output logic [BW-1:0] data_out,
  output logic          valid_out,
  output logic          vc_out,
  output logic          pause0,
  output logic          pause1,
  output logic          empty0,
  output logic          empty1,
  output logic          full0,
  output logic          full1,
  output logic          err_overflow
);
  localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] L_HI    = (AW+1)'(HIGH_TH);
  localparam logic [AW:0] L_LO    = (AW+1)'(LOW_TH);
  logic [BW-1:0]        r_mem [2][DEPTH];
  logic [1:0][AW-1:0]   r_wp, r_rp;
  logic [1:0][AW:0]     r_cnt, w_nc;
  logic [1:0]           r_pause, w_ne, w_pop, w_push, w_vin;
  logic [1:0][BW-1:0]   w_din, w_head;
  logic                 r_rr, w_adv;
  assign w_vin    = {valid1_in, valid0_in};
  assign w_din    = {data1_in, data0_in};
  assign w_head   = {r_mem[1][r_rp[1]], r_mem[0][r_rp[0]]};
  assign w_ne     = {|r_cnt[1], |r_cnt[0]};
  assign w_adv    = ENB & (out_ready | ~valid_out);
  assign w_pop[0] = w_adv & w_ne[0] & (~w_ne[1] | ~r_rr);
  assign w_pop[1] = w_adv & w_ne[1] & (~w_ne[0] | r_rr);
  assign empty0   = ~w_ne[0];
  assign empty1   = ~w_ne[1];
  assign full0    = r_cnt[0] == L_DEPTH;
  assign full1    = r_cnt[1] == L_DEPTH;
  assign pause0   = r_pause[0];
  assign pause1   = r_pause[1];
  // A full FIFO still takes a push when the same edge pops it.
  always_comb begin
    w_push = '0;
    w_nc   = '0;
    for (int c = 0; c < 2; c++) begin
      w_push[c] = w_vin[c] & ((r_cnt[c] != L_DEPTH) | w_pop[c]);
      w_nc[c]   = r_cnt[c] + (AW+1)'(w_push[c]) - (AW+1)'(w_pop[c]);
    end
  end
  always_ff @(posedge clk)
    for (int c = 0; c < 2; c++)
      if (w_push[c]) r_mem[c][r_wp[c]] <= w_din[c];
  always_ff @(posedge clk or negedge reset_L)
    if (!reset_L) begin
      r_wp         <= '0;
      r_rp         <= '0;
      r_cnt        <= '0;
      r_pause      <= '0;
      r_rr         <= 1'b0;
      data_out     <= '0;
      valid_out    <= 1'b0;
      vc_out       <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (w_push[c]) r_wp[c] <= r_wp[c] + AW'(1);
        if (w_pop[c]) r_rp[c] <= r_rp[c] + AW'(1);
        r_cnt[c]   <= w_nc[c];
        r_pause[c] <= (w_nc[c] >= L_HI) ? 1'b1 : (w_nc[c] <= L_LO) ? 1'b0 : r_pause[c];
      end
      if (|(w_vin & ~w_push)) err_overflow <= 1'b1;
      if (|w_pop) begin
        data_out  <= w_pop[1] ? w_head[1] : w_head[0];
        vc_out    <= w_pop[1];
        r_rr      <= w_pop[0];
        valid_out <= 1'b1;
      end else if (w_adv | ~ENB) valid_out <= 1'b0;
    end
endmodule

// File: tb/tb_vc_flow_arbiter.sv
// tb_vc_flow_arbiter: directed stimulus feeding a scoreboard queue; a negedge monitor
// checks every accepted output word, plus direct flag/pause checks.
module tb_vc_flow_arbiter;
  localparam int BW = 10, DEPTH = 4, AW = 2, HIGH_TH = 3, LOW_TH = 1;
  logic clk = 0, reset_L = 0, ENB = 0, valid0_in = 0, valid1_in = 0, out_ready = 0;
  logic [BW-1:0] data0_in = '0, data1_in = '0, data_out;
  logic valid_out, vc_out, pause0, pause1, empty0, empty1, full0, full1, err_overflow;
  logic [BW:0] q[$];
  int n_cmp = 0, n_err = 0;

  vc_flow_arbiter #(.BW(BW), .DEPTH(DEPTH), .AW(AW), .HIGH_TH(HIGH_TH), .LOW_TH(LOW_TH)) dut (
    .clk(clk), .reset_L(reset_L), .ENB(ENB), .valid0_in(valid0_in), .data0_in(data0_in),
    .valid1_in(valid1_in), .data1_in(data1_in), .out_ready(out_ready), .data_out(data_out),
    .valid_out(valid_out), .vc_out(vc_out), .pause0(pause0), .pause1(pause1),
    .empty0(empty0), .empty1(empty1), .full0(full0), .full1(full1), .err_overflow(err_overflow));

  always #5 clk = ~clk;

  initial assert (LOW_TH < HIGH_TH && HIGH_TH <= DEPTH) else $error("bad thresholds");

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_L = 0;
    tick();
    reset_L = 1;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && q.size() > 0; i++) tick();
    chk("drain_left", q.size(), 0);
  endtask

  always @(negedge clk)
    if (reset_L && valid_out && out_ready) begin
      if (q.size() == 0) chk("unexpected_out", {vc_out, data_out}, 32'hFFFF_FFFF);
      else chk("out", {vc_out, data_out}, q.pop_front());
    end

  initial begin
    tick();
    tick();
    reset_L = 1;
    chk("rst_valid", valid_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_vc", vc_out, 0);
    chk("rst_pause", {pause1, pause0}, 0);
    chk("rst_empty", {empty1, empty0}, 2'b11);
    chk("rst_full", {full1, full0}, 0);
    chk("rst_err", err_overflow, 0);
    valid0_in = 1; data0_in = 10'h155;
    tick();
    valid0_in = 0;
    chk("push_empty0", empty0, 0);
    #2 reset_L = 0;
    #1 chk("async_rst_empty0", empty0, 1);
    tick();
    reset_L = 1;

    ENB = 1; out_ready = 1;
    for (int i = 1; i <= 3; i++) begin
      valid0_in = 1; data0_in = BW'(i);
      q.push_back({1'b0, BW'(i)});
      tick();
    end
    valid0_in = 0;
    repeat (4) tick();
    chk("single_idle_valid", valid_out, 0);
    chk("single_q", q.size(), 0);

    do_reset();
    ENB = 0;
    valid0_in = 1; valid1_in = 1; data0_in = 10'h0A; data1_in = 10'h1A;
    tick();
    data0_in = 10'h0B; data1_in = 10'h1B;
    tick();
    valid0_in = 0; valid1_in = 0;
    chk("preload_valid", valid_out, 0);
    q.push_back({1'b0, 10'h0A}); q.push_back({1'b1, 10'h1A});
    q.push_back({1'b0, 10'h0B}); q.push_back({1'b1, 10'h1B});
    ENB = 1;
    drain();

    ENB = 0;
    valid0_in = 1; valid1_in = 1; data0_in = 10'h0A; data1_in = 10'h1A;
    tick();
    valid0_in = 0; valid1_in = 0;
    out_ready = 0; ENB = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("bp_data", data_out, 10'h0A);
      chk("bp_valid", valid_out, 1);
      chk("bp_empty1", empty1, 0);
      tick();
    end
    q.push_back({1'b0, 10'h0A}); q.push_back({1'b1, 10'h1A});
    out_ready = 1;
    drain();

    ENB = 0;
    for (int i = 1; i <= 5; i++) begin
      valid1_in = 1; data1_in = BW'(10'h100 + i);
      if (i <= 4) q.push_back({1'b1, BW'(10'h100 + i)});
      tick();
      chk("hys_pause1", pause1, i >= 3);
      chk("hys_full1", full1, i >= 4);
      chk("hys_err", err_overflow, i == 5);
    end
    valid1_in = 0;
    ENB = 1;
    tick();
    chk("drain_pause1_c3", pause1, 1);
    tick();
    chk("drain_pause1_c2", pause1, 1);
    tick();
    chk("drain_pause1_c1", pause1, 0);
    drain();

    do_reset();
    ENB = 0;
    for (int i = 1; i <= 4; i++) begin
      valid0_in = 1; data0_in = BW'(10'h200 + i);
      q.push_back({1'b0, BW'(10'h200 + i)});
      tick();
    end
    chk("full0", full0, 1);
    chk("full_pause0", pause0, 1);
    ENB = 1; data0_in = 10'h3FF;
    q.push_back({1'b0, 10'h3FF});
    tick();
    valid0_in = 0;
    chk("pp_full0", full0, 1);
    chk("pp_err", err_overflow, 0);
    drain();
    tick();
    tick();
    chk("end_valid", valid_out, 0);
    chk("end_empty", {empty1, empty0}, 2'b11);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
